// File: rtl/rv32i_wb_port_arbiter.sv
// ============================================================================
// rv32i_wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and an out-of-band multi-cycle unit (MDU: mul/div, late
// loads). The pipeline owns the port by default; MDU results wait in a small
// in-order FIFO and drain into slots the pipeline leaves idle. When a queued
// result has waited too long, or the FIFO is full with another result
// knocking, the pipeline is frozen and the FIFO is drained completely.
//
// Parameters
//   DEPTH         MDU result FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT  cycles the FIFO head may be passed over before a forced
//                 drain (>= 1)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active high
//   wb_regwrite  in   pipeline WB write enable
//   wb_rd        in   pipeline destination register
//   wb_data      in   pipeline write data
//   mdu_valid    in   MDU result valid
//   mdu_rd       in   MDU destination register
//   mdu_data     in   MDU result
//   mdu_ready    out  FIFO can accept (handshake = valid & ready at clk rise)
//   rf_we        out  register-file write enable
//   rf_waddr     out  register-file write address (0 when rf_we = 0)
//   rf_wdata     out  register-file write data (0 when rf_we = 0)
//   stall        out  freeze pipeline; upstream holds WB inputs while high
//   fifo_count   out  occupied FIFO entries
// ============================================================================
module rv32i_wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_regwrite,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_rd,
    input  logic [31:0]              mdu_data,
    output logic                     mdu_ready,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [4:0]      rd_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [SW-1:0]   starve;

    logic            pipe_req;
    logic            head_grant;
    logic            pipe_grant;
    logic            accept;
    logic            push;
    logic            pop;

    // Ready looks only at the registered count, so a pop in the same cycle
    // never opens a slot early; reset forces it low.
    assign mdu_ready = (count < COUNT_FULL) && !rst;
    assign accept    = mdu_valid && mdu_ready;

    // A result aimed at x0 completes its handshake but is dropped here.
    assign push      = accept && (mdu_rd != 5'd0);

    // Writes to x0 never claim the port, leaving the slot free for the FIFO.
    assign pipe_req  = wb_regwrite && (wb_rd != 5'd0);

    // While draining, the head always wins; otherwise it takes idle slots.
    assign head_grant = (count != '0) && ((state == STALL) || !pipe_req);
    assign pipe_grant = pipe_req && !head_grant && (state != STALL);
    assign pop        = head_grant;

    assign stall      = (state == STALL);
    assign fifo_count = count;

    // Write-port mux, zeroed whenever nothing is granted or reset is held.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (head_grant) begin
                rf_we    = 1'b1;
                rf_waddr = rd_mem[rd_ptr];
                rf_wdata = data_mem[rd_ptr];
            end else if (pipe_grant) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = wb_data;
            end
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    // FIFO storage and pointers; pointers wrap naturally since DEPTH is a
    // power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem[i]   <= 5'd0;
                data_mem[i] <= 32'd0;
            end
        end else begin
            if (push) begin
                rd_mem[wr_ptr]   <= mdu_rd;
                data_mem[wr_ptr] <= mdu_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Counts cycles the head is passed over; saturates at the trip point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if ((count == '0) || pop) begin
            starve <= '0;
        end else if (starve != STARVE_MAX) begin
            starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STALL drains until empty; a push landing alongside the final pop
    // leaves one fresh entry, which is handled as an ordinary pending one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (push) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (((starve == STARVE_MAX) && !pop) ||
                             ((count == COUNT_FULL) && mdu_valid)) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (count == COUNT_ONE) begin
                    state_next = PEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32i_wb_port_arbiter.sv
// ============================================================================
// tb_rv32i_wb_port_arbiter
//
// Directed scenarios followed by randomized traffic for the write-port
// arbiter. Expected outputs come from a queue-based reference model of the
// arbitration rules; scenario-specific constants are also checked.
// ============================================================================
module tb_rv32i_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic                   clk;
    logic                   rst;
    logic                   wb_regwrite;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_data;
    logic                   mdu_valid;
    logic [4:0]             mdu_rd;
    logic [31:0]            mdu_data;
    logic                   mdu_ready;
    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [31:0]            rf_wdata;
    logic                   stall;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t modelQ[$];
    int     modelWaited;
    bit     modelDraining;

    int testCount = 0;
    int failCount = 0;

    rv32i_wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall       (stall),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelHeadGrant();
        return (modelQ.size() > 0) &&
               (modelDraining || !(wb_regwrite && (wb_rd != 5'd0)));
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelWaited   = 0;
        modelDraining = 0;
    endtask

    // Advances the model by one rising edge using the current inputs.
    task automatic modelEdge();
        int     sizeBefore;
        bit     popped;
        bit     accepted;
        entry_t e;
        sizeBefore = modelQ.size();
        popped     = modelHeadGrant();
        accepted   = mdu_valid && (sizeBefore < DEPTH);
        if (popped) void'(modelQ.pop_front());
        if (modelDraining) begin
            modelDraining = (sizeBefore - 1) > 0;
        end else if (sizeBefore > 0) begin
            modelDraining = ((modelWaited == STARVE_LIMIT - 1) && !popped) ||
                            ((sizeBefore == DEPTH) && mdu_valid);
        end
        if ((sizeBefore == 0) || popped) modelWaited = 0;
        else if (modelWaited < STARVE_LIMIT - 1) modelWaited++;
        if (accepted && (mdu_rd != 5'd0)) begin
            e.rd   = mdu_rd;
            e.data = mdu_data;
            modelQ.push_back(e);
        end
    endtask

    task automatic checkOutput();
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        expWe   = 1'b0;
        expAddr = 5'd0;
        expData = 32'd0;
        if (modelHeadGrant()) begin
            expWe   = 1'b1;
            expAddr = modelQ[0].rd;
            expData = modelQ[0].data;
        end else if (wb_regwrite && (wb_rd != 5'd0) && !modelDraining) begin
            expWe   = 1'b1;
            expAddr = wb_rd;
            expData = wb_data;
        end
        checkVal("rf_we",      32'(rf_we),      32'(expWe));
        checkVal("rf_waddr",   32'(rf_waddr),   32'(expAddr));
        checkVal("rf_wdata",   rf_wdata,        expData);
        checkVal("mdu_ready",  32'(mdu_ready),  32'(modelQ.size() < DEPTH));
        checkVal("stall",      32'(stall),      32'(modelDraining));
        checkVal("fifo_count", 32'(fifo_count), 32'(modelQ.size()));
    endtask

    // Drives inputs just after a rising edge and checks at the falling edge.
    task automatic applyStimulus(input logic rw, input logic [4:0] rd, input logic [31:0] d,
                                 input logic v, input logic [4:0] mrd, input logic [31:0] md);
        wb_regwrite = rw;
        wb_rd       = rd;
        wb_data     = d;
        mdu_valid   = v;
        mdu_rd      = mrd;
        mdu_data    = md;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Asserts reset mid-cycle, checks that every output is low, then
    // releases it with the MDU quiet so nothing is pushed at release.
    task automatic resetPulse(input string tag);
        rst = 1'b1;
        #2;
        checkVal({tag, "_rf_we"},      32'(rf_we),      32'd0);
        checkVal({tag, "_rf_waddr"},   32'(rf_waddr),   32'd0);
        checkVal({tag, "_rf_wdata"},   rf_wdata,        32'd0);
        checkVal({tag, "_mdu_ready"},  32'(mdu_ready),  32'd0);
        checkVal({tag, "_stall"},      32'(stall),      32'd0);
        checkVal({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        mdu_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        modelReset();
        #1;
    endtask

    initial begin
        bit          holdMdu;
        int          busyPct;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        v;
        logic [4:0]  mrd;
        logic [31:0] md;

        rst         = 1'b1;
        wb_regwrite = 1'b1;
        wb_rd       = 5'd5;
        wb_data     = 32'h0BAD_F00D;
        mdu_valid   = 1'b1;
        mdu_rd      = 5'd4;
        mdu_data    = 32'h1;
        modelReset();
        #1;
        resetPulse("por");

        // Pipeline-only writes, including a write to x0.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        checkVal("pipe_we",    32'(rf_we),    32'd1);
        checkVal("pipe_waddr", 32'(rf_waddr), 32'd5);
        checkVal("pipe_wdata", rf_wdata,      32'hDEAD_BEEF);
        clockEdge();
        applyStimulus(1'b1, 5'd0, 32'hAAAA_5555, 1'b0, 5'd0, 32'd0);
        checkVal("pipe_x0_we", 32'(rf_we), 32'd0);
        clockEdge();

        // Idle drain: result appears the cycle after acceptance.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
        checkVal("idle_ready", 32'(mdu_ready), 32'd1);
        checkVal("idle_nobypass", 32'(rf_we), 32'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("idle_we",    32'(rf_we),      32'd1);
        checkVal("idle_waddr", 32'(rf_waddr),   32'd7);
        checkVal("idle_wdata", rf_wdata,        32'h1234_5678);
        checkVal("idle_count", 32'(fifo_count), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("idle_empty", 32'(fifo_count), 32'd0);
        clockEdge();

        // Starvation: the head is passed over four times, then forced out.
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h9999_0000);
        clockEdge();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
            checkVal("starve_pipe", 32'(rf_waddr), 32'd3);
            checkVal("starve_nostall", 32'(stall), 32'd0);
            clockEdge();
        end
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        checkVal("starve_stall", 32'(stall),    32'd1);
        checkVal("starve_waddr", 32'(rf_waddr), 32'd9);
        checkVal("starve_wdata", rf_wdata,      32'h9999_0000);
        clockEdge();
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        checkVal("starve_release", 32'(stall),    32'd0);
        checkVal("starve_resume",  32'(rf_waddr), 32'd3);
        clockEdge();

        // Full FIFO with a third result waiting.
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 32'hA1);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd2, 32'hA2);
        checkVal("full_ready_one", 32'(mdu_ready), 32'd1);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hA3);
        checkVal("full_ready", 32'(mdu_ready),  32'd0);
        checkVal("full_count", 32'(fifo_count), 32'd2);
        checkVal("full_pipe",  32'(rf_waddr),   32'd4);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hA3);
        checkVal("full_stall",  32'(stall),     32'd1);
        checkVal("full_x1",     32'(rf_waddr),  32'd1);
        checkVal("full_ready_pop_same", 32'(mdu_ready), 32'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hA3);
        checkVal("full_stall2", 32'(stall),     32'd1);
        checkVal("full_x2",     32'(rf_waddr),  32'd2);
        checkVal("full_ready_after", 32'(mdu_ready), 32'd1);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
        checkVal("full_pend_stall", 32'(stall),      32'd0);
        checkVal("full_pend_count", 32'(fifo_count), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("full_x3", 32'(rf_waddr), 32'd3);
        clockEdge();

        // Simultaneous push and pop, then a result aimed at x0.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA_0010);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hAAAA_0011);
        checkVal("sim_pop10", 32'(rf_waddr),   32'd10);
        checkVal("sim_count", 32'(fifo_count), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("sim_count_kept", 32'(fifo_count), 32'd1);
        checkVal("sim_pop11",      32'(rf_waddr),   32'd11);
        checkVal("sim_data11",     rf_wdata,        32'hAAAA_0011);
        clockEdge();
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 32'hFFFF);
        checkVal("x0_ready", 32'(mdu_ready), 32'd1);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("x0_count", 32'(fifo_count), 32'd0);
        checkVal("x0_we",    32'(rf_we),      32'd0);
        clockEdge();

        // Reset in the middle of a drain with two queued results.
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 32'hB1);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd2, 32'hB2);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hB3);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'hB3);
        checkVal("rst_pre_count", 32'(fifo_count), 32'd2);
        checkVal("rst_pre_stall", 32'(stall),      32'd1);
        resetPulse("middrain");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkVal("rst_post_ready", 32'(mdu_ready),  32'd1);
        checkVal("rst_post_count", 32'(fifo_count), 32'd0);
        clockEdge();

        // Randomized traffic: heavy pipeline pressure, then light.
        holdMdu = 1'b0;
        v   = 1'b0;
        mrd = 5'd0;
        md  = 32'd0;
        for (int i = 0; i < 600; i++) begin
            busyPct = (i < 300) ? 85 : 35;
            rw = ($urandom_range(99) < busyPct);
            rd = 5'($urandom_range(31));
            d  = $urandom;
            if (!holdMdu) begin
                v   = 1'($urandom_range(1));
                mrd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                md  = $urandom;
            end
            applyStimulus(rw, rd, d, v, mrd, md);
            holdMdu = v && (modelQ.size() >= DEPTH);
            clockEdge();
            if (i == 450) begin
                resetPulse("rand");
                holdMdu = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
